// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS control slice: opcode/funct
// codes, FSM state encoding, ALU operation codes, PC source codes and the
// instruction-class flag bundle produced by the decoder.
package mc_ctrl_pkg;

    localparam int unsigned OP_W    = 6;
    localparam int unsigned STATE_W = 4;
    localparam int unsigned ALUOP_W = 3;
    localparam int unsigned PCSRC_W = 2;

    // Primary opcodes (IR[31:26])
    localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
    localparam logic [OP_W-1:0] OP_J     = 6'h02;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
    localparam logic [OP_W-1:0] OP_BNE   = 6'h05;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
    localparam logic [OP_W-1:0] OP_ANDI  = 6'h0C;
    localparam logic [OP_W-1:0] OP_ORI   = 6'h0D;
    localparam logic [OP_W-1:0] OP_XORI  = 6'h0E;
    localparam logic [OP_W-1:0] OP_LW    = 6'h23;
    localparam logic [OP_W-1:0] OP_SW    = 6'h2B;

    // R-type function codes (IR[5:0])
    localparam logic [OP_W-1:0] FN_ADD = 6'h20;
    localparam logic [OP_W-1:0] FN_SUB = 6'h22;
    localparam logic [OP_W-1:0] FN_AND = 6'h24;
    localparam logic [OP_W-1:0] FN_OR  = 6'h25;
    localparam logic [OP_W-1:0] FN_XOR = 6'h26;
    localparam logic [OP_W-1:0] FN_NOR = 6'h27;
    localparam logic [OP_W-1:0] FN_SLT = 6'h2A;

    // ALU operation codes
    localparam logic [ALUOP_W-1:0] ALU_AND = 3'b000;
    localparam logic [ALUOP_W-1:0] ALU_OR  = 3'b001;
    localparam logic [ALUOP_W-1:0] ALU_ADD = 3'b010;
    localparam logic [ALUOP_W-1:0] ALU_XOR = 3'b011;
    localparam logic [ALUOP_W-1:0] ALU_NOR = 3'b100;
    localparam logic [ALUOP_W-1:0] ALU_SUB = 3'b110;
    localparam logic [ALUOP_W-1:0] ALU_SLT = 3'b111;

    // PC source select
    localparam logic [PCSRC_W-1:0] PC_SRC_SEQ = 2'b00;
    localparam logic [PCSRC_W-1:0] PC_SRC_BR  = 2'b01;
    localparam logic [PCSRC_W-1:0] PC_SRC_JMP = 2'b10;

    typedef enum logic [STATE_W-1:0] {
        S_IF       = 4'd0,
        S_ID       = 4'd1,
        S_EXE_R    = 4'd2,
        S_WB_R     = 4'd3,
        S_EXE_I    = 4'd4,
        S_WB_I     = 4'd5,
        S_MEM_ADDR = 4'd6,
        S_MEM_RD   = 4'd7,
        S_WB_M     = 4'd8,
        S_MEM_WR   = 4'd9,
        S_BR       = 4'd10,
        S_JMP      = 4'd11
    } state_t;

    // One-hot-ish class flags; all zero means the instruction is unsupported
    typedef struct packed {
        logic rtype;   // R-type with a supported funct
        logic ialu;    // addi/andi/ori/xori
        logic lw;
        logic sw;
        logic br;      // beq or bne
        logic bne;
        logic jmp;
    } inst_class_t;

endpackage

// File: rtl/mips_mc_ctrl_if.sv
// Control bundle between the multi-cycle controller and its datapath.
// master: controller side (drives enables/selects/fields, samples inst_code/zero)
// slave : datapath side (drives inst_code/zero, samples everything else)
interface mips_mc_ctrl_if #(
    parameter int unsigned ALU_OP_W = 3
);
    logic [31:0]         inst_code;
    logic                zero;
    logic                ir_write;
    logic                pc_write;
    logic [1:0]          pc_src;
    logic                reg_write;
    logic                reg_dst;
    logic                mem_to_reg;
    logic                mem_write;
    logic                alu_src_b;
    logic [ALU_OP_W-1:0] alu_op;
    logic [4:0]          rs;
    logic [4:0]          rt;
    logic [4:0]          rd;
    logic [31:0]         imm_ext;
    logic [25:0]         jaddr;
    logic                illegal;
    logic [3:0]          state;

    modport master (
        input  inst_code, zero,
        output ir_write, pc_write, pc_src, reg_write, reg_dst, mem_to_reg,
               mem_write, alu_src_b, alu_op, rs, rt, rd, imm_ext, jaddr,
               illegal, state
    );

    modport slave (
        output inst_code, zero,
        input  ir_write, pc_write, pc_src, reg_write, reg_dst, mem_to_reg,
               mem_write, alu_src_b, alu_op, rs, rt, rd, imm_ext, jaddr,
               illegal, state
    );
endinterface

// File: rtl/mc_inst_decode.sv
// Combinational instruction decoder for the IR.
// Inputs : ir        - latched instruction word
// Outputs: rs/rt/rd  - register fields
//          imm_ext   - sign- or zero-extended immediate
//          jaddr     - 26-bit jump index
//          cls       - instruction-class flags (all zero = unsupported)
//          alu_op_r  - ALU op for a supported R-type funct
//          alu_op_i  - ALU op for an I-type ALU opcode
module mc_inst_decode
    import mc_ctrl_pkg::*;
(
    input  logic [31:0]        ir,
    output logic [4:0]         rs,
    output logic [4:0]         rt,
    output logic [4:0]         rd,
    output logic [31:0]        imm_ext,
    output logic [25:0]        jaddr,
    output inst_class_t        cls,
    output logic [ALUOP_W-1:0] alu_op_r,
    output logic [ALUOP_W-1:0] alu_op_i
);

    logic [OP_W-1:0] opcode;
    logic [OP_W-1:0] funct;
    logic            funct_ok;
    logic            zext;

    assign opcode = ir[31:26];
    assign funct  = ir[5:0];
    assign rs     = ir[25:21];
    assign rt     = ir[20:16];
    assign rd     = ir[15:11];
    assign jaddr  = ir[25:0];

    // Logical immediates are zero-extended; everything else sign-extends
    assign zext    = (opcode == OP_ANDI) || (opcode == OP_ORI) || (opcode == OP_XORI);
    assign imm_ext = zext ? {16'h0000, ir[15:0]} : {{16{ir[15]}}, ir[15:0]};

    // R-type funct to ALU op
    always_comb begin
        alu_op_r = ALU_ADD;
        funct_ok = 1'b1;
        case (funct)
            FN_ADD:  alu_op_r = ALU_ADD;
            FN_SUB:  alu_op_r = ALU_SUB;
            FN_AND:  alu_op_r = ALU_AND;
            FN_OR:   alu_op_r = ALU_OR;
            FN_XOR:  alu_op_r = ALU_XOR;
            FN_NOR:  alu_op_r = ALU_NOR;
            FN_SLT:  alu_op_r = ALU_SLT;
            default: funct_ok = 1'b0;
        endcase
    end

    // I-type ALU opcode to ALU op
    always_comb begin
        alu_op_i = ALU_ADD;
        case (opcode)
            OP_ANDI: alu_op_i = ALU_AND;
            OP_ORI:  alu_op_i = ALU_OR;
            OP_XORI: alu_op_i = ALU_XOR;
            default: alu_op_i = ALU_ADD;
        endcase
    end

    // Instruction classification
    always_comb begin
        cls       = '0;
        cls.rtype = (opcode == OP_RTYPE) && funct_ok;
        cls.ialu  = (opcode == OP_ADDI) || zext;
        cls.lw    = (opcode == OP_LW);
        cls.sw    = (opcode == OP_SW);
        cls.br    = (opcode == OP_BEQ) || (opcode == OP_BNE);
        cls.bne   = (opcode == OP_BNE);
        cls.jmp   = (opcode == OP_J);
    end

endmodule

// File: rtl/mips_mc_ctrl.sv
// Multi-cycle MIPS-subset controller: latches the fetched word into the IR,
// walks the per-class state sequence and decodes datapath controls.
// Ports: clk, rst (async, active-high);
//        bus.master - inst_code/zero in; enables, selects, IR fields,
//                     illegal pulse and debug state out.
// Outputs are a Moore decode of the state and IR registers (pc_write in BR
// additionally follows zero); all enables are held low while rst is high.
module mips_mc_ctrl
    import mc_ctrl_pkg::*;
#(
    parameter logic [31:0] IR_RESET = 32'h0000_0000,
    parameter int unsigned ALU_OP_W = 3
) (
    input  logic          clk,
    input  logic          rst,
    mips_mc_ctrl_if.master bus
);

    state_t             state_q;
    state_t             state_d;
    logic [31:0]        ir_q;
    inst_class_t        cls;
    logic [ALUOP_W-1:0] alu_op_r;
    logic [ALUOP_W-1:0] alu_op_i;
    logic [ALUOP_W-1:0] alu_op_c;
    logic               ir_write_c;
    logic               pc_write_c;
    logic               reg_write_c;
    logic               mem_write_c;
    logic               illegal_c;

    mc_inst_decode u_decode (
        .ir       (ir_q),
        .rs       (bus.rs),
        .rt       (bus.rt),
        .rd       (bus.rd),
        .imm_ext  (bus.imm_ext),
        .jaddr    (bus.jaddr),
        .cls      (cls),
        .alu_op_r (alu_op_r),
        .alu_op_i (alu_op_i)
    );

    // State and instruction registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IF;
            ir_q    <= IR_RESET;
        end else begin
            state_q <= state_d;
            if (ir_write_c) begin
                ir_q <= bus.inst_code;
            end
        end
    end

    // Next-state and control decode
    always_comb begin
        state_d        = S_IF;
        ir_write_c     = 1'b0;
        pc_write_c     = 1'b0;
        reg_write_c    = 1'b0;
        mem_write_c    = 1'b0;
        illegal_c      = 1'b0;
        bus.pc_src     = PC_SRC_SEQ;
        bus.reg_dst    = 1'b0;
        bus.mem_to_reg = 1'b0;
        bus.alu_src_b  = 1'b0;
        alu_op_c       = ALU_ADD;

        case (state_q)
            S_IF: begin
                ir_write_c = 1'b1;
                pc_write_c = 1'b1;
                state_d    = S_ID;
            end
            S_ID: begin
                if (cls.rtype) begin
                    state_d = S_EXE_R;
                end else if (cls.ialu) begin
                    state_d = S_EXE_I;
                end else if (cls.lw || cls.sw) begin
                    state_d = S_MEM_ADDR;
                end else if (cls.br) begin
                    state_d = S_BR;
                end else if (cls.jmp) begin
                    state_d = S_JMP;
                end else begin
                    illegal_c = 1'b1;
                    state_d   = S_IF;
                end
            end
            S_EXE_R: begin
                alu_op_c = alu_op_r;
                state_d  = S_WB_R;
            end
            S_WB_R: begin
                reg_write_c = 1'b1;
                bus.reg_dst = 1'b1;
            end
            S_EXE_I: begin
                bus.alu_src_b = 1'b1;
                alu_op_c      = alu_op_i;
                state_d       = S_WB_I;
            end
            S_WB_I: begin
                reg_write_c = 1'b1;
            end
            S_MEM_ADDR: begin
                bus.alu_src_b = 1'b1;
                state_d       = cls.lw ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                state_d = S_WB_M;
            end
            S_WB_M: begin
                reg_write_c    = 1'b1;
                bus.mem_to_reg = 1'b1;
            end
            S_MEM_WR: begin
                mem_write_c = 1'b1;
            end
            S_BR: begin
                alu_op_c   = ALU_SUB;
                bus.pc_src = PC_SRC_BR;
                // beq takes the branch on zero, bne on not-zero
                pc_write_c = bus.zero ^ cls.bne;
            end
            S_JMP: begin
                pc_write_c = 1'b1;
                bus.pc_src = PC_SRC_JMP;
            end
            default: state_d = S_IF;
        endcase
    end

    // Enables are forced low for the whole reset window
    assign bus.ir_write  = ir_write_c  & ~rst;
    assign bus.pc_write  = pc_write_c  & ~rst;
    assign bus.reg_write = reg_write_c & ~rst;
    assign bus.mem_write = mem_write_c & ~rst;
    assign bus.illegal   = illegal_c   & ~rst;
    assign bus.alu_op    = ALU_OP_W'(alu_op_c);
    assign bus.state     = STATE_W'(state_q);

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Self-checking bench for mips_mc_ctrl: directed test-plan cases, a reset
// taken in the middle of a store, then randomized instructions, all checked
// against a per-instruction phase list built from the instruction's class.
module tb_mips_mc_ctrl;

    typedef struct {
        int st;
        int irw;
        int pcw;
        int pcs;
        int rw;
        int rdst;
        int m2r;
        int mw;
        int asb;
        int aop;
        int ill;
    } exp_t;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    exp_t exp_q[$];

    mips_mc_ctrl_if #(.ALU_OP_W(3)) bus ();

    mips_mc_ctrl #(
        .IR_RESET (32'h0000_0000),
        .ALU_OP_W (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t ph(input int st);
        exp_t e;
        e     = '{default: 0};
        e.st  = st;
        e.aop = 2;
        return e;
    endfunction

    // ALU code for an R-type funct, -1 if unsupported
    function automatic int r_aop(input logic [5:0] fn);
        case (fn)
            6'h20:   return 2;
            6'h22:   return 6;
            6'h24:   return 0;
            6'h25:   return 1;
            6'h26:   return 3;
            6'h27:   return 4;
            6'h2A:   return 7;
            default: return -1;
        endcase
    endfunction

    // Expected cycle-by-cycle behaviour of one instruction, IF to last state
    function automatic void build(input logic [31:0] inst, input logic z);
        exp_t        e;
        logic [5:0]  op;
        int          aop;
        op = inst[31:26];
        exp_q.delete();
        e = ph(0); e.irw = 1; e.pcw = 1; exp_q.push_back(e);
        e = ph(1);
        case (op)
            6'h00: begin
                aop = r_aop(inst[5:0]);
                if (aop < 0) begin
                    e.ill = 1; exp_q.push_back(e);
                end else begin
                    exp_q.push_back(e);
                    e = ph(2); e.aop = aop; exp_q.push_back(e);
                    e = ph(3); e.rw = 1; e.rdst = 1; exp_q.push_back(e);
                end
            end
            6'h08, 6'h0C, 6'h0D, 6'h0E: begin
                exp_q.push_back(e);
                e = ph(4); e.asb = 1;
                e.aop = (op == 6'h08) ? 2 : (op == 6'h0C) ? 0 : (op == 6'h0D) ? 1 : 3;
                exp_q.push_back(e);
                e = ph(5); e.rw = 1; exp_q.push_back(e);
            end
            6'h23: begin
                exp_q.push_back(e);
                e = ph(6); e.asb = 1; exp_q.push_back(e);
                e = ph(7); exp_q.push_back(e);
                e = ph(8); e.rw = 1; e.m2r = 1; exp_q.push_back(e);
            end
            6'h2B: begin
                exp_q.push_back(e);
                e = ph(6); e.asb = 1; exp_q.push_back(e);
                e = ph(9); e.mw = 1; exp_q.push_back(e);
            end
            6'h04, 6'h05: begin
                exp_q.push_back(e);
                e = ph(10); e.aop = 6; e.pcs = 1;
                e.pcw = (op == 6'h04) ? int'(z) : int'(!z);
                exp_q.push_back(e);
            end
            6'h02: begin
                exp_q.push_back(e);
                e = ph(11); e.pcw = 1; e.pcs = 2; exp_q.push_back(e);
            end
            default: begin
                e.ill = 1; exp_q.push_back(e);
            end
        endcase
    endfunction

    // Called at a falling edge with the DUT in IF; returns at the falling edge
    // after the instruction's final state, with the DUT back in IF.
    task automatic run_inst(input logic [31:0] inst, input logic z);
        logic [5:0]  op;
        logic [31:0] imm;
        op = inst[31:26];
        imm = (op == 6'h0C || op == 6'h0D || op == 6'h0E) ?
              {16'h0000, inst[15:0]} : {{16{inst[15]}}, inst[15:0]};
        bus.inst_code = inst;
        bus.zero      = z;
        build(inst, z);
        for (int k = 0; k < exp_q.size(); k++) begin
            #1;
            chk("state",      32'(bus.state),      32'(exp_q[k].st));
            chk("ir_write",   32'(bus.ir_write),   32'(exp_q[k].irw));
            chk("pc_write",   32'(bus.pc_write),   32'(exp_q[k].pcw));
            chk("pc_src",     32'(bus.pc_src),     32'(exp_q[k].pcs));
            chk("reg_write",  32'(bus.reg_write),  32'(exp_q[k].rw));
            chk("reg_dst",    32'(bus.reg_dst),    32'(exp_q[k].rdst));
            chk("mem_to_reg", 32'(bus.mem_to_reg), 32'(exp_q[k].m2r));
            chk("mem_write",  32'(bus.mem_write),  32'(exp_q[k].mw));
            chk("alu_src_b",  32'(bus.alu_src_b),  32'(exp_q[k].asb));
            chk("alu_op",     32'(bus.alu_op),     32'(exp_q[k].aop));
            chk("illegal",    32'(bus.illegal),    32'(exp_q[k].ill));
            if (k == 1) begin
                chk("rs",    32'(bus.rs),    32'(inst[25:21]));
                chk("rt",    32'(bus.rt),    32'(inst[20:16]));
                chk("rd",    32'(bus.rd),    32'(inst[15:11]));
                chk("jaddr", 32'(bus.jaddr), 32'(inst[25:0]));
                if (op != 6'h00 && op != 6'h02)
                    chk("imm_ext", bus.imm_ext, imm);
            end
            @(negedge clk);
        end
    endtask

    // Random instruction, weighted towards supported encodings
    function automatic logic [31:0] rand_inst();
        logic [5:0]  ops [10];
        logic [5:0]  fns [7];
        logic [31:0] r;
        logic [5:0]  op;
        ops = '{6'h00, 6'h02, 6'h04, 6'h05, 6'h08, 6'h0C, 6'h0D, 6'h0E, 6'h23, 6'h2B};
        fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A};
        r  = $urandom();
        op = ($urandom_range(0, 7) == 0) ? 6'($urandom()) : ops[$urandom_range(0, 9)];
        r[31:26] = op;
        if (op == 6'h00 && $urandom_range(0, 5) != 0)
            r[5:0] = fns[$urandom_range(0, 6)];
        return r;
    endfunction

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        rst           = 1'b1;
        bus.inst_code = 32'h0;
        bus.zero      = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_state",     32'(bus.state),     32'd0);
        chk("rst_ir_write",  32'(bus.ir_write),  32'd0);
        chk("rst_pc_write",  32'(bus.pc_write),  32'd0);
        chk("rst_reg_write", 32'(bus.reg_write), 32'd0);
        chk("rst_ir",        bus.imm_ext,        32'd0);
        rst = 1'b0;

        // Directed test-plan cases
        run_inst(32'h0000_0000, 1'b0);
        run_inst(32'h0022_1820, 1'b0);
        run_inst(32'h3423_FFFF, 1'b0);
        run_inst(32'h8C23_FFFC, 1'b0);
        run_inst(32'hAC23_0004, 1'b0);
        run_inst(32'h1022_0003, 1'b1);
        run_inst(32'h1022_0003, 1'b0);
        run_inst(32'h1422_0003, 1'b1);
        run_inst(32'h1422_0003, 1'b0);

        // Reset taken while the store is in MEM_WR
        bus.inst_code = 32'hAC23_0004;
        repeat (3) @(negedge clk);
        #1;
        chk("mw_state", 32'(bus.state),     32'd9);
        chk("mw_write", 32'(bus.mem_write), 32'd1);
        rst = 1'b1;
        #1;
        chk("mwrst_write", 32'(bus.mem_write), 32'd0);
        chk("mwrst_state", 32'(bus.state),     32'd0);
        chk("mwrst_pcw",   32'(bus.pc_write),  32'd0);
        chk("mwrst_ir",    32'(bus.jaddr),     32'd0);
        chk("mwrst_imm",   bus.imm_ext,        32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_inst(32'h0800_0010, 1'b0);

        // Randomized instruction stream
        for (int i = 0; i < 200; i++)
            run_inst(rand_inst(), 1'($urandom_range(0, 1)));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mips_mc_ctrl.md
Name: mips_mc_ctrl

Overview:
- Decode/control stage directly downstream of the PC + instruction-ROM fetch stage.
- Consumes the fetched 32-bit instruction word and latches it into an instruction register (IR).
- Decodes the IR and runs a multi-cycle FSM. The FSM sequences PC update, register-file write, data-memory access and ALU operation selection for a MIPS subset.
- Drives the datapath's enables and muxes; receives only the ALU zero flag back.

Parameters:
- IR_RESET, 32'h0000_0000, IR value after reset.
- ALU_OP_W, 3, width of alu_op encoding.

Ports:
- clk  in  1  clock; all state and IR update on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- inst_code  in  32  instruction word from fetch stage; stable during IF state.
- zero  in  1  ALU result==0 flag; valid during BR state.
- ir_write  out  1  IR capture enable (observability; also internal).
- pc_write  out  1  PC update enable.
- pc_src  out  2  00 PC+4, 01 branch target (PC+4+imm<<2), 10 jump {PC[31:28],jaddr,2'b00}.
- reg_write  out  1  register-file write enable.
- reg_dst  out  1  0 = rt, 1 = rd.
- mem_to_reg  out  1  write-back source: 0 ALU result, 1 memory data.
- mem_write  out  1  data-memory write enable.
- alu_src_b  out  1  0 = register B, 1 = imm_ext.
- alu_op  out  ALU_OP_W  000 AND, 001 OR, 010 ADD, 011 XOR, 100 NOR, 110 SUB, 111 SLT.
- rs, rt, rd  out  5 each  IR fields [25:21], [20:16], [15:11].
- imm_ext  out  32  extended IR[15:0].
- jaddr  out  26  IR[25:0].
- illegal  out  1  one-cycle pulse in ID on unsupported opcode/funct.
- state  out  4  current FSM state (debug).

Behaviour:
- Reset (async, any time, including mid-instruction):
  - state=IF, IR=IR_RESET.
  - All enables forced to 0 while rst is high: ir_write, pc_write, reg_write, mem_write, illegal.
  - The first IF after rst deasserts proceeds normally.
- Outputs are Moore, decoded from state and IR; no combinational path from inst_code to any output except through IR.
- States (4-bit):
  - IF=0: ir_write=1, pc_write=1, pc_src=00. IR<=inst_code on the exiting edge. Next state is ID.
  - ID=1: decode IR.
    - R-type (op 0) -> EXE_R.
    - addi/andi/ori/xori -> EXE_I.
    - lw/sw -> MEM_ADDR.
    - beq/bne -> BR.
    - j -> JMP.
    - Anything else: illegal=1, next state is IF, no side effects.
  - EXE_R=2: alu_src_b=0, alu_op from funct: 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x26 XOR, 0x27 NOR, 0x2A SLT. Next state is WB_R.
  - WB_R=3: reg_write=1, reg_dst=1, mem_to_reg=0. Next state is IF.
  - EXE_I=4: alu_src_b=1, alu_op: addi ADD, andi AND, ori OR, xori XOR. Next state is WB_I.
  - WB_I=5: reg_write=1, reg_dst=0, mem_to_reg=0. Next state is IF.
  - MEM_ADDR=6: alu_src_b=1, alu_op=ADD. Next state is MEM_RD for lw, MEM_WR for sw.
  - MEM_RD=7: memory read cycle, no enables. Next state is WB_M.
  - WB_M=8: reg_write=1, reg_dst=0, mem_to_reg=1. Next state is IF.
  - MEM_WR=9: mem_write=1. Next state is IF.
  - BR=10: alu_src_b=0, alu_op=SUB, pc_src=01. pc_write = zero for beq, ~zero for bne. Next state is IF.
  - JMP=11: pc_write=1, pc_src=10. Next state is IF.
  - Unused codes 12-15 go to IF.
- Outputs not listed for a state are 0 (alu_op defaults to ADD).
- Immediate extension:
  - Sign-extend for addi, lw, sw, beq, bne.
  - Zero-extend for andi, ori, xori.
- Opcodes: R=0x00, j=0x02, beq=0x04, bne=0x05, addi=0x08, andi=0x0C, ori=0x0D, xori=0x0E, lw=0x23, sw=0x2B.
- R-type with an unlisted funct (including 0x00, so encoding 32'h0 is a NOP) raises illegal in ID and returns to IF.
- Latency in cycles, IF through return to IF:
  - R-type / I-ALU: 4.
  - lw: 5.
  - sw: 4.
  - beq / bne: 3.
  - j: 3.
  - illegal / NOP: 2.
- rd is written to r0 without special handling; the register file enforces r0=0.

Decomposition:
- Package mc_ctrl_pkg holds:
  - opcode and funct localparams;
  - state encodings;
  - alu_op codes;
  - pc_src codes.
- One combinational sub-module, mc_inst_decode:
  - input: IR;
  - outputs: field split, imm_ext, instruction-class flags, alu_op mapping.
- The FSM and IR stay in mips_mc_ctrl.

Test Plan:
- Reset then inst_code=32'h0000_0000.
  - Required: IF→ID→IF, illegal=1 for one cycle in ID, no reg_write.
- inst_code=32'h0022_1820 (add $3,$1,$2).
  - Required: states 0,1,2,3,0.
  - EXE_R: alu_op=010.
  - WB_R: reg_write=1, reg_dst=1, rd=3.
- inst_code=32'h3423_FFFF (ori $3,$1,0xFFFF).
  - Required: imm_ext=32'h0000_FFFF, alu_op=001, WB_I writes rt=3.
- inst_code=32'h8C23_FFFC (lw) followed by 32'hAC23_0004 (sw).
  - lw: imm_ext=32'hFFFF_FFFC, 5-cycle sequence, mem_to_reg=1 in WB_M.
  - sw: mem_write=1 only in MEM_WR.
- inst_code=32'h1022_0003 (beq).
  - zero=1 in BR: pc_write=1, pc_src=01.
  - zero=0 in BR: pc_write=0.
  - Same instruction with op 0x05 (bne): inverse result.
- Assert rst during MEM_WR.
  - Required: mem_write drops the same cycle, state=0, IR=0.
  - After release, j 32'h0800_0010 gives pc_src=10, jaddr=26'h10.
